// File: rtl/simon32_iter_ctrl.sv
// Iterative Simon 32/64 encryptor: one round per clock through a single round
// block, with the 64-bit key schedule expanded on the fly in a 4-word window.

module sigle_block (
  input  logic [15:0] in_low,
  input  logic [15:0] in_high,
  input  logic [15:0] in_key,
  output logic [15:0] out_low,
  output logic [15:0] out_high
);
  logic [15:0] f;

  always_comb begin
    f        = ({in_low[14:0], in_low[15]} & {in_low[7:0], in_low[15:8]})
             ^ {in_low[13:0], in_low[15:14]};
    out_low  = in_high ^ f ^ in_key;
    out_high = in_low;
  end
endmodule

module simon32_iter_ctrl #(
  parameter int unsigned NUM_ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pt,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ct,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // z0 stored MSB-first: round r uses bit (31 - r).
  localparam logic [31:0] Z0   = 32'b1111_1010_0010_0101_0110_0001_1100_1101;
  localparam logic [4:0]  LAST = 5'(NUM_ROUNDS - 1);

  state_t      state, state_next;
  logic [15:0] x, y;
  logic [15:0] w0, w1, w2, w3;
  logic [4:0]  rcnt;
  logic [31:0] ct_q;

  logic [15:0] rnd_low, rnd_high;
  logic [15:0] tmp, knew;
  logic        last_round;

  sigle_block u_round (
    .in_low  (x),
    .in_high (y),
    .in_key  (w0),
    .out_low (rnd_low),
    .out_high(rnd_high)
  );

  always_comb begin
    tmp  = {w3[2:0], w3[15:3]} ^ w1;
    knew = w0 ^ tmp ^ {tmp[0], tmp[15:1]} ^ 16'hFFFC ^ {15'b0, Z0[5'd31 - rcnt]};
  end

  assign last_round = (rcnt == LAST);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_ct     = ct_q;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      w3   <= '0;
      rcnt <= '0;
      ct_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x    <= in_pt[31:16];
            y    <= in_pt[15:0];
            {w3, w2, w1, w0} <= in_key;
            rcnt <= '0;
          end
        end
        RUN: begin
          x    <= rnd_low;
          y    <= rnd_high;
          {w3, w2, w1, w0} <= {knew, w3, w2, w1};
          rcnt <= rcnt + 5'd1;
          // Capture the result separately so out_ct stays put outside DONE.
          if (last_round) ct_q <= {rnd_low, rnd_high};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simon32_iter_ctrl.sv
// Directed bench for simon32_iter_ctrl: standard vector, back-pressure,
// back-to-back blocks, ignored input, mid-run reset and a one-round instance.

module tb_simon32_iter_ctrl;
  localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] PT  = 32'h6565_6877;
  localparam logic [31:0] CT  = 32'hC69B_E9BB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_pt, out_ct;
  logic [63:0] in_key;

  logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_busy;
  logic [31:0] n1_in_pt, n1_out_ct;
  logic [63:0] n1_in_key;

  int checks = 0;
  int failures = 0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, hs_cnt = 0, rise_cyc = 0;
  logic ov_prev = 1'b0;
  int n, busy_n, ir_bad, bad, a0, h0, r1;

  always #5 clk = ~clk;

  simon32_iter_ctrl #(.NUM_ROUNDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_ct(out_ct), .busy(busy)
  );

  simon32_iter_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .in_pt(n1_in_pt), .in_key(n1_in_key), .out_valid(n1_out_valid),
    .out_ready(n1_out_ready), .out_ct(n1_out_ct), .busy(n1_busy)
  );

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (out_valid && out_ready) hs_cnt++;
  end

  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
  end

  function automatic logic [15:0] rl(input logic [15:0] v, input int unsigned s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] v, input int unsigned s);
    return (v >> s) | (v << (16 - s));
  endfunction

  // Reference encryptor using the array form of the key schedule.
  function automatic logic [31:0] simon_model(input logic [31:0] pt, input logic [63:0] key,
                                               input int unsigned nr);
    logic [15:0] k [0:31];
    logic [15:0] xm, ym, t;
    logic [31:0] z;
    z = 32'b1111_1010_0010_0101_0110_0001_1100_1101;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int unsigned i = 4; i < 32; i++) begin
      t    = rr(k[i-1], 3) ^ k[i-3];
      t    = t ^ rr(t, 1);
      k[i] = ~k[i-4] ^ t ^ 16'(z[31-(i-4)]) ^ 16'd3;
    end
    xm = pt[31:16];
    ym = pt[15:0];
    for (int unsigned i = 0; i < nr; i++) begin
      t  = xm;
      xm = ym ^ (rl(xm, 1) & rl(xm, 8)) ^ rl(xm, 2) ^ k[i];
      ym = t;
    end
    return {xm, ym};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ov(input string tag);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pt = '0; in_key = '0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_in_pt = '0; n1_in_key = '0; n1_out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ct", 64'(out_ct), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_n1_out_ct", 64'(n1_out_ct), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Standard vector, latency and busy duration
    @(negedge clk);
    in_valid = 1'b1; in_pt = PT; in_key = KEY; out_ready = 1'b1;
    h0 = hs_cnt;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; busy_n = 0; ir_bad = 0;
    while (!out_valid && n < 100) begin
      if (busy) busy_n++;
      if (in_ready) ir_bad++;
      @(negedge clk);
      n++;
    end
    chk("t1_latency", 64'(n), 64'd32);
    chk("t1_busy_cycles", 64'(busy_n), 64'd32);
    chk("t1_in_ready_run", 64'(ir_bad), 64'd0);
    chk("t1_out_ct", 64'(out_ct), 64'(CT));
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_in_ready_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_ov_after_hs", 64'(out_valid), 64'd0);
    chk("t1_in_ready_idle", 64'(in_ready), 64'd1);
    chk("t1_hs_count", 64'(hs_cnt - h0), 64'd1);

    // Output back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_pt = PT; in_key = KEY;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov("t2_ov_timeout");
    chk("t2_latency", 64'(n), 64'd32);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_ct === CT && in_ready === 1'b0)) bad++;
    end
    chk("t2_hold_stable", 64'(bad), 64'd0);
    h0 = hs_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ov_after_hs", 64'(out_valid), 64'd0);
    chk("t2_in_ready_idle", 64'(in_ready), 64'd1);
    chk("t2_hs_count", 64'(hs_cnt - h0), 64'd1);

    // Back-to-back with in_valid held high
    a0 = acc_cnt;
    in_valid = 1'b1; in_pt = PT; in_key = KEY;
    @(negedge clk);
    wait_ov("t3_ov1_timeout");
    chk("t3_out_ct1", 64'(out_ct), 64'(CT));
    in_pt = 32'h0;
    n = 0;
    while (acc_cnt == a0 + 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    r1 = rise_cyc;
    chk("t3_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("t3_gap", 64'(acc_cyc - r1), 64'd2);
    wait_ov("t3_ov2_timeout");
    chk("t3_out_ct2", 64'(out_ct), 64'(simon_model(32'h0, KEY, 32)));
    @(negedge clk);

    // Inputs toggled during RUN are ignored
    a0 = acc_cnt;
    in_valid = 1'b1; in_pt = PT; in_key = KEY;
    @(negedge clk);
    repeat (20) begin
      in_valid = 1'($urandom_range(0, 1));
      in_pt = $urandom;
      in_key = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_ov("t4_ov_timeout");
    chk("t4_out_ct", 64'(out_ct), 64'(CT));
    chk("t4_accepts", 64'(acc_cnt - a0), 64'd1);
    @(negedge clk);

    // Reset in the middle of a run
    in_valid = 1'b1; in_pt = PT; in_key = KEY;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    h0 = hs_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_in_rst", 64'(busy), 64'd0);
    chk("t5_in_ready_in_rst", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready_rel", 64'(in_ready), 64'd1);
    chk("t5_busy_rel", 64'(busy), 64'd0);
    chk("t5_ov_rel", 64'(out_valid), 64'd0);
    chk("t5_out_ct_rel", 64'(out_ct), 64'd0);
    chk("t5_no_hs", 64'(hs_cnt - h0), 64'd0);
    @(negedge clk);
    in_valid = 1'b1; in_pt = PT; in_key = KEY;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov("t5_ov_timeout");
    chk("t5_out_ct", 64'(out_ct), 64'(CT));
    @(negedge clk);

    // Single-round instance
    n1_in_valid = 1'b1; n1_in_pt = 32'h0001_0000; n1_in_key = '0; n1_out_ready = 1'b1;
    @(negedge clk);
    n1_in_valid = 1'b0;
    chk("t6_busy", 64'(n1_busy), 64'd1);
    chk("t6_ov_early", 64'(n1_out_valid), 64'd0);
    @(negedge clk);
    chk("t6_ov", 64'(n1_out_valid), 64'd1);
    chk("t6_out_ct", 64'(n1_out_ct), 64'h0004_0001);
    chk("t6_busy_done", 64'(n1_busy), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/simon32_iter_ctrl.md
Name: simon32_iter_ctrl

Overview:
- Iterative Simon 32/64 encryption engine built around one instance of the 16-bit round block `sigle_block`.
- Sequences one round per clock for NUM_ROUNDS rounds and expands the 64-bit key on the fly, one new round key per cycle.
- Uses valid/ready handshakes on both the input side (plaintext + key) and the output side (ciphertext).
- Sits between the block-level input staging and the ciphertext consumer.

Parameters:
- NUM_ROUNDS, 32, rounds per block; legal range 1..32 (32 = standard Simon 32/64).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, plaintext/key presented.
- in_ready, output, 1, engine can accept a block.
- in_pt, input, 32, plaintext {x,y}; x = [31:16], y = [15:0].
- in_key, input, 64, key {k3,k2,k1,k0}; k0 = [15:0].
- out_valid, output, 1, ciphertext valid.
- out_ready, input, 1, consumer accepts ciphertext.
- out_ct, output, 32, ciphertext {x,y}.
- busy, output, 1, high while in the RUN state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x/y/key window/round counter cleared to 0. in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, out_ct=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load x=in_pt[31:16], y=in_pt[15:0], window {w3,w2,w1,w0}=in_key, rcnt=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, drive the round block with in_low=x, in_high=y, in_key=w0. Register x<=out_low, y<=out_high.
  - Key update: tmp = ror3(w3) ^ w1; knew = w0 ^ tmp ^ ror1(tmp) ^ 16'hFFFC ^ z[rcnt]. Shift the window: {w3,w2,w1,w0} <= {knew,w3,w2,w1}.
  - z = first 32 bits of Simon sequence z0, MSB-first: 1111_1010_0010_0101_0110_0001_1100_1101. Bit 0 (leftmost) is used in round 0.
  - rcnt increments each cycle. On the cycle with rcnt==NUM_ROUNDS-1, apply the last round and go to DONE.
- DONE:
  - out_valid=1 and out_ct={x,y}, both held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE.
  - in_ready stays 0 in DONE, so a new block is accepted no earlier than the cycle after the output handshake.
- Latency: input accept at edge E. Rounds occur at edges E+1..E+NUM_ROUNDS. out_valid is high from just after E+NUM_ROUNDS; 32 cycles for the default.
- Throughput: one block per NUM_ROUNDS+2 cycles with out_ready held high.
- in_valid outside IDLE is ignored; in_pt/in_key are sampled only on the accept edge.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded, with no output handshake.
- out_ct outside DONE: holds its last registered value. Consumers must qualify it with out_valid.
- All arithmetic is 16-bit; rotations are modulo 16; no carries.

Test Plan:
- Standard vector: in_key=64'h1918_1110_0908_0100, in_pt=32'h6565_6877, out_ready=1 -> out_valid rises 32 cycles after accept with out_ct=32'hC69B_E9BB; in_ready=0 throughout; busy=1 for exactly 32 cycles.
- Output back-pressure: same vector with out_ready=0 for 10 cycles after out_valid -> out_valid and out_ct=32'hC69B_E9BB held stable; in_ready stays 0; one handshake when out_ready=1, then IDLE with in_ready=1.
- Back-to-back: two blocks (the vector above, then the same key with pt=0) presented with in_valid held high -> second accept occurs exactly 2 cycles after the first's out_valid rises; first out_ct=C69BE9BB; second result matches the software model.
- Ignored input: toggle in_valid with random in_pt/in_key during RUN -> result still C69BE9BB; no extra accept.
- Reset mid-run: deassert rst_n at round 15 for 1 cycle -> out_valid=0, busy=0, in_ready=1 after release; the next vector encrypts correctly.
- NUM_ROUNDS=1: key 0, pt=32'h0001_0000 -> out_ct=32'h0004_0001 (x'=0^0^rol2(1)^k0=4, y'=1), produced one cycle after accept.
